// File: rtl/count_step_ctrl.sv
// rtl/count_step_ctrl.sv - debounced count-button step requester with clear; optional hold auto-repeat under AUTO_REPEAT_EN
module count_step_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn,
   input  logic       clr_in,
   input  logic       step_ready,
   output logic       step_valid,
   output logic       clr_pulse,
   output logic [7:0] missed_steps
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

   logic            btn_s1, btn_s2;
   logic            clr_s1, clr_s2, clr_s3;
   logic [DB_W-1:0] db_cnt;
   logic            btn_db;
   state_t          state, state_nxt;
   logic            step_evt, step_evt_q;
   logic            clr_evt;
   logic            xfer;

`ifdef AUTO_REPEAT_EN
   localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   logic [TMR_W-1:0] tmr;
   logic             hold_hit, period_hit;

   assign hold_hit   = (tmr == TMR_W'(REPEAT_DELAY));
   assign period_hit = (tmr == TMR_W'(REPEAT_PERIOD - 1));

   // Hold timer: idle at zero, restarts on every emitted step so REPEAT spacing is exact
   always_ff @(posedge clk) begin
      if (reset || state == IDLE || step_evt)
         tmr <= '0;
      else
         tmr <= tmr + TMR_W'(1);
   end
`endif

   assign clr_evt = clr_s2 & ~clr_s3;
   assign xfer    = step_valid & step_ready;

   // Two-flop synchronizers for both raw inputs, plus the clear edge-detect history
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
         clr_s1 <= 1'b0;
         clr_s2 <= 1'b0;
         clr_s3 <= 1'b0;
      end else begin
         btn_s1 <= btn;
         btn_s2 <= btn_s1;
         clr_s1 <= clr_in;
         clr_s2 <= clr_s1;
         clr_s3 <= clr_s2;
      end
   end

   // Debounce: flip only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk) begin
      if (reset) begin
         db_cnt <= '0;
         btn_db <= 1'b0;
      end else if (btn_s2 != btn_db) begin
         if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            btn_db <= btn_s2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end else begin
         db_cnt <= '0;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // FSM next state: a debounced release always wins over a pending repeat
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (btn_db) state_nxt = HOLD;
         HOLD: begin
            if (!btn_db)
               state_nxt = IDLE;
`ifdef AUTO_REPEAT_EN
            else if (hold_hit)
               state_nxt = REPEAT;
`endif
         end
         REPEAT:  if (!btn_db) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: step event on the press and on each auto-repeat tick
   always_comb begin
      step_evt = 1'b0;
      case (state)
         IDLE:    step_evt = btn_db;
`ifdef AUTO_REPEAT_EN
         HOLD:    step_evt = btn_db && hold_hit;
         REPEAT:  step_evt = btn_db && period_hit;
`endif
         default: step_evt = 1'b0;
      endcase
   end

   // Step handshake, drop counter and clear; a clear edge overrides everything else
   always_ff @(posedge clk) begin
      if (reset) begin
         step_evt_q   <= 1'b0;
         step_valid   <= 1'b0;
         clr_pulse    <= 1'b0;
         missed_steps <= 8'd0;
      end else begin
         step_evt_q <= step_evt;
         clr_pulse  <= clr_evt;
         if (clr_evt) begin
            step_valid   <= 1'b0;
            missed_steps <= 8'd0;
         end else begin
            if (step_evt_q && (!step_valid || xfer))
               step_valid <= 1'b1;
            else if (xfer)
               step_valid <= 1'b0;
            if (step_evt_q && step_valid && !xfer && missed_steps != 8'hFF)
               missed_steps <= missed_steps + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_count_step_ctrl.sv
// tb/tb_count_step_ctrl.sv - directed self-checking bench for count_step_ctrl
module tb_count_step_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn;
   logic       clr_in;
   logic       step_ready;
   logic       step_valid;
   logic       clr_pulse;
   logic [7:0] missed_steps;

   int n_vec = 0;
   int n_err = 0;

   logic [127:0] exp_sv;

   count_step_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (20),
      .REPEAT_PERIOD  (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn         (btn),
      .clr_in      (clr_in),
      .step_ready  (step_ready),
      .step_valid  (step_valid),
      .clr_pulse   (clr_pulse),
      .missed_steps(missed_steps)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_btn(input string tag, input int hold, input int total);
      for (int c = 0; c < total; c++) begin
         btn = (c < hold);
         cyc();
         check($sformatf("%s sv c%0d", tag, c), {31'd0, step_valid}, {31'd0, exp_sv[c]});
      end
      btn = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      btn = 1'b0;
      clr_in = 1'b0;
      step_ready = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      cyc();
      check("rst step_valid", {31'd0, step_valid}, 0);
      check("rst clr_pulse", {31'd0, clr_pulse}, 0);
      check("rst missed", {24'd0, missed_steps}, 0);
      reset = 1'b0;
      cyc();

      // single press: one step at cycle 7
      exp_sv = '0; exp_sv[7] = 1'b1;
      run_btn("press10", 10, 25);
      check("press10 missed", {24'd0, missed_steps}, 0);

      // 3-cycle glitch is one short of the debounce window, 4 cycles is just enough
      exp_sv = '0;
      run_btn("glitch3", 3, 20);
      exp_sv = '0; exp_sv[7] = 1'b1;
      run_btn("press4", 4, 20);

      // chatter every 2 cycles never debounces
      for (int c = 0; c < 50; c++) begin
         btn = (c < 40) && ((c / 2) % 2 == 0);
         cyc();
         check($sformatf("toggle sv c%0d", c), {31'd0, step_valid}, 0);
      end
      btn = 1'b0;

      // long hold: auto-repeat steps only when the feature is built in
      exp_sv = '0; exp_sv[7] = 1'b1;
`ifdef AUTO_REPEAT_EN
      exp_sv[28] = 1'b1; exp_sv[36] = 1'b1; exp_sv[44] = 1'b1;
      exp_sv[52] = 1'b1; exp_sv[60] = 1'b1;
`endif
      run_btn("hold60", 60, 80);

      // backpressure during a long hold
      do_reset();
      step_ready = 1'b0;
      for (int c = 0; c < 60; c++) begin
         btn = 1'b1;
         cyc();
         if (c == 6)  check("bp sv c6", {31'd0, step_valid}, 0);
         if (c == 7)  check("bp sv c7", {31'd0, step_valid}, 1);
         if (c == 30) check("bp sv c30", {31'd0, step_valid}, 1);
         if (c == 59) begin
            check("bp sv c59", {31'd0, step_valid}, 1);
`ifdef AUTO_REPEAT_EN
            check("bp missed c59", {24'd0, missed_steps}, 4);
`else
            check("bp missed c59", {24'd0, missed_steps}, 0);
`endif
         end
      end
      btn = 1'b0;
      for (int c = 0; c < 20; c++) cyc();
      check("bp sv held", {31'd0, step_valid}, 1);
      step_ready = 1'b1;
      cyc();
      check("bp sv drop", {31'd0, step_valid}, 0);
      cyc();
      check("bp sv stays", {31'd0, step_valid}, 0);

      // drop count on a second press, then clear zeroes it
      do_reset();
      step_ready = 1'b0;
      exp_sv = {128{1'b1}} << 7;
      run_btn("bp1", 10, 25);
      exp_sv = {128{1'b1}};
      run_btn("bp2", 10, 25);
      check("bp2 missed", {24'd0, missed_steps}, 1);
      step_ready = 1'b1;
      cyc();
      check("bp2 sv drop", {31'd0, step_valid}, 0);
      check("bp2 missed kept", {24'd0, missed_steps}, 1);
      for (int c = 0; c < 6; c++) begin
         clr_in = 1'b1;
         cyc();
         check($sformatf("clr pulse c%0d", c), {31'd0, clr_pulse}, (c == 2) ? 1 : 0);
         if (c == 2) check("clr missed", {24'd0, missed_steps}, 0);
      end

      // clear edge coincides with the press step event: clear wins
      clr_in = 1'b0;
      for (int c = 0; c < 6; c++) cyc();
      for (int c = 0; c < 25; c++) begin
         btn = (c < 10);
         clr_in = (c >= 5);
         cyc();
         check($sformatf("coin pulse c%0d", c), {31'd0, clr_pulse}, (c == 7) ? 1 : 0);
         check($sformatf("coin sv c%0d", c), {31'd0, step_valid}, 0);
      end
      check("coin missed", {24'd0, missed_steps}, 0);

      // clear level held high does not block presses
      exp_sv = '0; exp_sv[7] = 1'b1;
      run_btn("clrhigh", 10, 25);

      // reset mid-hold with a pending step, button kept down
      clr_in = 1'b0;
      do_reset();
      step_ready = 1'b0;
      for (int c = 0; c < 40; c++) begin
         btn = 1'b1;
         cyc();
      end
      check("mid sv", {31'd0, step_valid}, 1);
`ifdef AUTO_REPEAT_EN
      check("mid missed", {24'd0, missed_steps}, 2);
`endif
      reset = 1'b1;
      cyc();
      check("mid rst sv", {31'd0, step_valid}, 0);
      check("mid rst missed", {24'd0, missed_steps}, 0);
      check("mid rst clr", {31'd0, clr_pulse}, 0);
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         cyc();
         check($sformatf("post rst sv c%0d", c), {31'd0, step_valid}, (c >= 7) ? 1 : 0);
      end
      btn = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
